subtractor_4bit_serial: RTL

Bit-serial 4-bit subtractor with a valid/ready handshake on both sides. It computes diff = a − b − bin and the borrow-out, one bit per clock from LSB to MSB. It is the inverse-arithmetic companion to the 4-bit ripple adder and serves as a low-area multi-cycle datapath element. Operands are captured on an input handshake, the result is buffered, and the result is held until the consumer accepts it.

---
 rtl/subtractor_4bit_serial.sv | 135 +++++++++++++
 1 files changed

// File: rtl/subtractor_4bit_serial.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first.
// Operands captured on an input handshake; result held until accepted.
module subtractor_4bit_serial #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t state;
    state_t state_nx;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [WIDTH-1:0] res_nx;
    logic [CNT_W-1:0] cnt;
    logic             br;

    logic             a_i;
    logic             b_i;
    logic             d_i;
    logic             br_nx;
    logic             accept;
    logic             calc;
    logic             last;
    logic             release_hold;

    // One full-subtractor cell applied to the current LSB of the operands.
    always_comb begin
        a_i    = a_sr[0];
        b_i    = b_sr[0];
        d_i    = a_i ^ b_i ^ br;
        br_nx  = (~a_i & b_i) | (~(a_i ^ b_i) & br);
        res_nx = (res_sr >> 1) | {d_i, {(WIDTH-1){1'b0}}};
    end

    // State register; reset always returns to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and handshake decode.
    always_comb begin
        state_nx     = state;
        in_ready     = 1'b0;
        accept       = 1'b0;
        calc         = 1'b0;
        last         = 1'b0;
        release_hold = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept   = 1'b1;
                    state_nx = CALC;
                end
            end
            CALC: begin
                calc = 1'b1;
                if (cnt == LAST) begin
                    last     = 1'b1;
                    state_nx = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    release_hold = 1'b1;
                    state_nx     = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Serial datapath: capture, shift one bit per cycle, publish on the last bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr      <= '0;
            b_sr      <= '0;
            res_sr    <= '0;
            cnt       <= '0;
            br        <= 1'b0;
            diff      <= '0;
            bout      <= 1'b0;
            out_valid <= 1'b0;
        end else if (accept) begin
            a_sr   <= a;
            b_sr   <= b;
            br     <= bin;
            res_sr <= '0;
            cnt    <= '0;
        end else if (calc) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            br     <= br_nx;
            res_sr <= res_nx;
            if (last) begin
                cnt       <= '0;
                diff      <= res_nx;
                bout      <= br_nx;
                out_valid <= 1'b1;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end else if (release_hold) begin
            out_valid <= 1'b0;
        end
    end

endmodule
